// File: rtl/mips_run_ctrl_pkg.sv
// Shared types for the MIPS run/step/reset controller:
// controller states and halt cause encodings.
package mips_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_PAUSE,
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE     = 2'd0,
    C_HALT_REQ = 2'd1,
    C_TIMEOUT  = 2'd2,
    C_BREAK    = 2'd3
  } cause_t;

endpackage

// File: rtl/mips_run_ctrl_sync_debounce.sv
// 2-flop synchroniser plus stability-counter debounce.
// Ports: clk, rst (async low), din (raw), level (debounced), rise (1-cycle 0->1 pulse).
module mips_run_ctrl_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, s2_q;
  logic [CW-1:0] cnt;
  logic          accept;

  // Candidate is accepted once it has held for DEBOUNCE_CYCLES
  // consecutive cycles without a change of the synced value.
  assign accept = (s2 == s2_q) && (s2 != level) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s2_q  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_q <= s2;
      rise <= accept && s2;
      if (s2 != s2_q || s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step/reset controller driving the MIPS core rst, step and run_mode pins.
// Ports: clk, rst (async low), step_btn, run_sw, clear, halt_req in;
// core_rst, core_step, core_run_mode, halted, halt_cause, cycle_count out.
// Macro RUN_CTRL_BREAKPOINT_EN adds bp_valid, bp_addr, core_pc and cause 3.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_btn,
  input  logic                 run_sw,
  input  logic                 clear,
  input  logic                 halt_req,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic                 bp_valid,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          core_pc,
`endif
  output logic                 core_rst,
  output logic                 core_step,
  output logic                 core_run_mode,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  cause_t               cause_q, cause_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_inc;
  logic                 step_d, tmo, bp_hit;
  logic                 run_lvl, step_rise;
  logic                 run_rise, step_lvl;

  mips_run_ctrl_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .level(step_lvl),
    .rise (step_rise)
  );

  mips_run_ctrl_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run (
    .clk  (clk),
    .rst  (rst),
    .din  (run_sw),
    .level(run_lvl),
    .rise (run_rise)
  );

  // Saturating increment; the counter never wraps.
  assign cnt_inc = (&cycle_count) ? cycle_count
                                  : cycle_count + CNT_WIDTH'(1);
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = bp_valid && (core_pc == bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    cnt_d   = cycle_count;
    step_d  = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_PAUSE;
        else hold_d = hold_q + HW'(1);
      end
      S_PAUSE: begin
        if (halt_req) begin
          state_d = S_HALT;
          cause_d = C_HALT_REQ;
        end else if (run_lvl) begin
          state_d = S_RUN;
        end else if (step_rise) begin
          step_d = 1'b1;
          cnt_d  = cnt_inc;
          if (tmo) begin
            state_d = S_HALT;
            cause_d = C_TIMEOUT;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt_req) begin
          state_d = S_HALT;
          cause_d = C_HALT_REQ;
        end else if (tmo) begin
          state_d = S_HALT;
          cause_d = C_TIMEOUT;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = C_BREAK;
        end else if (!run_lvl) begin
          state_d = S_PAUSE;
        end
      end
      S_HALT: ;
      default: state_d = S_HOLD;
    endcase
    if (clear) begin
      state_d = S_HOLD;
      cause_d = C_NONE;
      hold_d  = '0;
      cnt_d   = '0;
      step_d  = 1'b0;
    end
  end

  // Outputs register the next-state view so pins track the state
  // register edge for edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HOLD;
      cause_q       <= C_NONE;
      hold_q        <= '0;
      cycle_count   <= '0;
      core_rst      <= 1'b0;
      core_step     <= 1'b0;
      core_run_mode <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      hold_q        <= hold_d;
      cycle_count   <= cnt_d;
      core_rst      <= (state_d != S_HOLD);
      core_step     <= step_d;
      core_run_mode <= (state_d == S_RUN);
      halted        <= (state_d == S_HALT);
    end
  end

  assign halt_cause = cause_q;

endmodule
